// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: shift-add multiply,
// restoring divide, then a sign-fix cycle before the result lands in HI/LO.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

  state_t             state_q;
  logic [CW-1:0]      cnt_q;
  logic               is_div_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [2*WIDTH-1:0] acc_q;
  logic               neg_lo_q;
  logic               neg_hi_q;
  logic               dz_q;
  logic [WIDTH-1:0]   a_raw_q;
  logic [WIDTH-1:0]   hi_q;
  logic [WIDTH-1:0]   lo_q;
  logic               busy_q;
  logic               done_q;
  logic               dbz_q;

  // Operand conditioning: magnitudes for signed ops, raw values for unsigned.
  logic             is_signed, a_neg, b_neg;
  logic [WIDTH-1:0] mag_a, mag_b;

  assign is_signed = ~op[0];
  assign a_neg     = is_signed & a[WIDTH-1];
  assign b_neg     = is_signed & b[WIDTH-1];
  assign mag_a     = a_neg ? -a : a;
  assign mag_b     = b_neg ? -b : b;

  // Multiply step: acc = {partial product, remaining multiplier bits}.
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;

  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

  // Divide step: acc = {partial remainder, dividend bits / quotient bits}.
  logic [WIDTH:0]     div_sh, div_diff;
  logic               div_ge;
  logic [2*WIDTH-1:0] div_next;

  assign div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff = div_sh - {1'b0, opnd_q};
  assign div_ge   = ~div_diff[WIDTH];
  assign div_next = {(div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0]),
                     acc_q[WIDTH-2:0], div_ge};

  logic [2*WIDTH-1:0] acc_d;
  assign acc_d = is_div_q ? div_next : mul_next;

  // Sign correction applied in the FIX cycle.
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quot_fix, rem_fix;
  logic [WIDTH-1:0]   fix_hi_d, fix_lo_d;

  assign prod_fix = neg_lo_q ? -acc_q : acc_q;
  assign quot_fix = neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
  assign rem_fix  = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

  always_comb begin
    fix_hi_d = prod_fix[2*WIDTH-1:WIDTH];
    fix_lo_d = prod_fix[WIDTH-1:0];
    if (is_div_q) begin
      if (dz_q) begin
        fix_hi_d = a_raw_q;
        fix_lo_d = '1;
      end else begin
        fix_hi_d = rem_fix;
        fix_lo_d = quot_fix;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      dz_q     <= 1'b0;
      a_raw_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      dbz_q  <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (hi_we) hi_q <= wdata;
          if (lo_we) lo_q <= wdata;
          if (start) begin
            state_q  <= S_RUN;
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            is_div_q <= op[1];
            opnd_q   <= op[1] ? mag_b : mag_a;
            acc_q    <= {{WIDTH{1'b0}}, (op[1] ? mag_a : mag_b)};
            neg_lo_q <= a_neg ^ b_neg;
            neg_hi_q <= a_neg;
            dz_q     <= op[1] & (b == '0);
            a_raw_q  <= a;
          end else begin
            state_q <= S_IDLE;
          end
        end
        // WIDTH step cycles followed by one hand-off cycle into FIX.
        S_RUN: begin
          if (cnt_q == LAST) begin
            state_q <= S_FIX;
          end else begin
            acc_q <= acc_d;
            cnt_q <= cnt_q + CW'(1);
          end
        end
        S_FIX: begin
          hi_q    <= fix_hi_d;
          lo_q    <= fix_lo_d;
          done_q  <= 1'b1;
          dbz_q   <= dz_q;
          busy_q  <= 1'b0;
          state_q <= S_DONE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: arithmetic reference model with a per-cycle
// compare process, directed cases with literal results, then random traffic.
module tb_mult_div_unit;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         Clk = 1'b0;
  logic         Reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0, b = '0, wdata = '0;
  logic         hi_we = 1'b0, lo_we = 1'b0;
  logic         busy, done, div_by_zero;
  logic [W-1:0] hi, lo;

  mult_div_unit #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .op(op), .a(a), .b(b),
    .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .hi(hi), .lo(lo)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference arithmetic on 64-bit integers.
  function automatic void calc(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                               output logic [W-1:0] rh, output logic [W-1:0] rl, output logic rdz);
    longint sx, sy, ux, uy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    rdz = 1'b0;
    rh = '0;
    rl = '0;
    case (o)
      2'b00: begin p = 64'(sx * sy); rh = p[63:32]; rl = p[31:0]; end
      2'b01: begin p = 64'(ux * uy); rh = p[63:32]; rl = p[31:0]; end
      default: begin
        if (y == '0) begin
          rdz = 1'b1; rh = x; rl = '1;
        end else begin
          if (o == 2'b10) begin q = sx / sy; r = sx % sy; end
          else            begin q = ux / uy; r = ux % uy; end
          p = 64'(q); rl = p[31:0];
          p = 64'(r); rh = p[31:0];
        end
      end
    endcase
  endfunction

  // Model: an operation occupies LAT cycles, then its result appears with done.
  logic [W-1:0] m_hi, m_lo, r_hi, r_lo;
  logic         m_done, m_dbz, r_dz;
  int           m_left;

  initial begin
    m_hi = '0; m_lo = '0; m_done = 0; m_dbz = 0; m_left = 0;
    r_hi = '0; r_lo = '0; r_dz = 0;
    forever begin
      @(posedge Clk);
      if (Reset) begin
        m_hi = '0; m_lo = '0; m_done = 0; m_dbz = 0; m_left = 0;
      end else begin
        m_done = 0; m_dbz = 0;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin
            m_hi = r_hi; m_lo = r_lo; m_done = 1; m_dbz = r_dz;
          end
        end else begin
          if (hi_we) m_hi = wdata;
          if (lo_we) m_lo = wdata;
          if (start) begin
            calc(op, a, b, r_hi, r_lo, r_dz);
            m_left = LAT;
          end
        end
      end
    end
  end

  initial begin
    @(posedge Clk);
    forever begin
      @(negedge Clk);
      chk("busy", busy, (m_left > 0) ? 1 : 0);
      chk("done", done, m_done);
      chk("div_by_zero", div_by_zero, m_dbz);
      chk("hi", hi, m_hi);
      chk("lo", lo, m_lo);
    end
  end

  // Drive a start for one edge; call at a negedge or just after a posedge.
  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1; op = o; a = x; b = y;
    @(posedge Clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int nb);
    bit got;
    got = 0;
    nb = 0;
    for (int i = 0; i < 100; i++) begin
      if (!got) begin
        @(negedge Clk);
        if (done) got = 1;
        else if (busy) nb++;
      end
    end
    chk("done_seen", 32'(got), 32'd1);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int  nb;
    bit  saw;
    repeat (2) @(negedge Clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_hi", hi, 0);
    chk("rst_lo", lo, 0);
    Reset = 1'b0;
    @(negedge Clk);

    issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_done(nb);
    chk("multu_busy_cycles", 32'(nb), 32'd34);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);
    chk("multu_busy_at_done", busy, 0);

    issue(2'b00, 32'hFFFF_FFFD, 32'd7);
    wait_done(nb);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFEB);

    @(negedge Clk);
    issue(2'b10, 32'hFFFF_FFF9, 32'd2);
    wait_done(nb);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    @(negedge Clk);
    issue(2'b11, 32'd100, 32'd0);
    wait_done(nb);
    chk("dz_flag", div_by_zero, 1);
    chk("dz_hi", hi, 32'h0000_0064);
    chk("dz_lo", lo, 32'hFFFF_FFFF);
    chk("dz_latency", 32'(nb), 32'd34);

    @(negedge Clk);
    issue(2'b11, 32'd100, 32'd7);
    wait_done(nb);
    chk("divu_lo", lo, 32'd14);
    chk("divu_hi", hi, 32'd2);
    chk("divu_dz", div_by_zero, 0);

    @(negedge Clk);
    issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(nb);
    chk("ovf_lo", lo, 32'h8000_0000);
    chk("ovf_hi", hi, 32'h0);

    // start and mthi while busy are both dropped
    @(negedge Clk);
    issue(2'b11, 32'd1000, 32'd3);
    repeat (5) @(negedge Clk);
    start = 1'b1; op = 2'b00; a = 32'd5; b = 32'd5; hi_we = 1'b1; wdata = 32'h1234;
    @(posedge Clk);
    #1 start = 1'b0; hi_we = 1'b0;
    wait_done(nb);
    chk("busy_ign_lo", lo, 32'd333);
    chk("busy_ign_hi", hi, 32'd1);

    // back-to-back issue from DONE
    issue(2'b01, 32'd6, 32'd7);
    chk("b2b_no_gap", busy, 1);
    wait_done(nb);
    chk("b2b_latency", 32'(nb), 32'd34);
    chk("b2b_lo", lo, 32'd42);
    chk("b2b_hi", hi, 32'd0);

    // reset mid-operation
    @(negedge Clk);
    issue(2'b00, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (10) @(negedge Clk);
    Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_hi", hi, 0);
    chk("rst_mid_lo", lo, 0);
    saw = 0;
    repeat (40) begin
      @(negedge Clk);
      if (done) saw = 1;
    end
    chk("rst_mid_no_done", 32'(saw), 32'd0);

    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hA5A5_A5A5;
    @(posedge Clk);
    #1 hi_we = 1'b0; lo_we = 1'b0;
    chk("mt_hi", hi, 32'hA5A5_A5A5);
    chk("mt_lo", lo, 32'hA5A5_A5A5);

    for (int i = 0; i < 3000; i++) begin
      @(negedge Clk);
      Reset = ($urandom_range(0, 499) == 0);
      start = ($urandom_range(0, 5) == 0);
      op    = 2'($urandom_range(0, 3));
      a     = pick();
      b     = pick();
      hi_we = ($urandom_range(0, 7) == 0);
      lo_we = ($urandom_range(0, 7) == 0);
      wdata = $urandom;
    end
    @(negedge Clk);
    Reset = 1'b0; start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    repeat (40) @(negedge Clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
